// File: rtl/slurm16_reset_seq_if.sv
// Reset-sequencer control/status bundle: CPU/watchdog requests in, staged resets and status out.
// The master drives requests and the slave (the sequencer) drives resets, ready and cause.
interface slurm16_reset_seq_if #(
    parameter int N_CH = 3
);
    logic            swrst_req;
    logic            wdt_en;
    logic            wdt_kick;
    logic [N_CH-1:0] RSTb_out;
    logic            ready;
    logic [1:0]      cause;

    modport master (
        output swrst_req, wdt_en, wdt_kick,
        input  RSTb_out, ready, cause
    );

    modport slave (
        input  swrst_req, wdt_en, wdt_kick,
        output RSTb_out, ready, cause
    );
endinterface

// File: rtl/slurm16_reset_seq.sv
// SLURM16 reset sequencer: holds all domains, releases channels in order, then supervises
// software reset and watchdog requests, recording the cause of the most recent reset.
module slurm16_reset_seq #(
    parameter int N_CH         = 3,
    parameter int HOLD_CYCLES  = 10000,
    parameter int STAGE_CYCLES = 16,
    parameter int WDT_CYCLES   = 6000000
) (
    input  logic                clk,
    input  logic                rst,
    slurm16_reset_seq_if.slave  bus
);
    localparam int HOLD_W  = $clog2(HOLD_CYCLES) + 1;
    localparam int STAGE_W = $clog2(STAGE_CYCLES) + 1;
    localparam int WDT_W   = $clog2(WDT_CYCLES) + 1;

    localparam logic [1:0] CAUSE_EXT = 2'd0;
    localparam logic [1:0] CAUSE_SW  = 2'd1;
    localparam logic [1:0] CAUSE_WDT = 2'd2;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_STAGE = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [STAGE_W-1:0]   stage_q, stage_d;
    logic [WDT_W-1:0]     wdt_q, wdt_d;
    logic [N_CH-1:0]      rstb_q, rstb_d;
    logic                 ready_q, ready_d;
    logic [1:0]           cause_q, cause_d;
    logic                 wdt_timeout;

    // A kick on the would-be timeout cycle suppresses the timeout.
    assign wdt_timeout = (state_q == ST_RUN) && bus.wdt_en && !bus.wdt_kick &&
                         (wdt_q == WDT_W'(WDT_CYCLES - 1));

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        state_d = state_q;
        hold_d  = hold_q;
        stage_d = stage_q;
        wdt_d   = wdt_q;
        rstb_d  = rstb_q;
        ready_d = ready_q;
        cause_d = cause_q;

        case (state_q)
            ST_HOLD: begin
                if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    hold_d  = '0;
                    stage_d = '0;
                    rstb_d  = N_CH'(1);
                    if (&rstb_d) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                    end else begin
                        state_d = ST_STAGE;
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_STAGE: begin
                if (stage_q == STAGE_W'(STAGE_CYCLES - 1)) begin
                    stage_d = '0;
                    // Channels release in order, so the reset vector is a thermometer code.
                    rstb_d  = (rstb_q << 1) | N_CH'(1);
                    if (&rstb_d) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                    end
                end else begin
                    stage_d = stage_q + STAGE_W'(1);
                end
            end
            ST_RUN: begin
                if (!bus.wdt_en || bus.wdt_kick) begin
                    wdt_d = '0;
                end else begin
                    wdt_d = wdt_q + WDT_W'(1);
                end
            end
            default: state_d = ST_HOLD;
        endcase

        // Software request outranks the watchdog when both land on the same edge.
        if (bus.swrst_req || wdt_timeout) begin
            cause_d = bus.swrst_req ? CAUSE_SW : CAUSE_WDT;
            state_d = ST_HOLD;
            hold_d  = '0;
            stage_d = '0;
            wdt_d   = '0;
            rstb_d  = '0;
            ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            state_q <= ST_HOLD;
            hold_q  <= '0;
            stage_q <= '0;
            wdt_q   <= '0;
            rstb_q  <= '0;
            ready_q <= 1'b0;
            cause_q <= CAUSE_EXT;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            stage_q <= stage_d;
            wdt_q   <= wdt_d;
            rstb_q  <= rstb_d;
            ready_q <= ready_d;
            cause_q <= cause_d;
        end
    end

    assign bus.RSTb_out = rstb_q;
    assign bus.ready    = ready_q;
    assign bus.cause    = cause_q;
endmodule

// File: tb/tb_slurm16_reset_seq.sv
// Directed bench for slurm16_reset_seq with small parameters; expected release timing is
// derived from HOLD/STAGE constants and checked edge by edge after every reset or trigger.
module tb_slurm16_reset_seq;
    localparam int N_CH    = 3;
    localparam int HOLD    = 8;
    localparam int STAGE   = 4;
    localparam int WDT     = 20;
    localparam int SEQ_LEN = HOLD + (N_CH - 1) * STAGE;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    slurm16_reset_seq_if #(.N_CH(N_CH)) bus ();

    slurm16_reset_seq #(
        .N_CH(N_CH), .HOLD_CYCLES(HOLD), .STAGE_CYCLES(STAGE), .WDT_CYCLES(WDT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sample and drive 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected reset vector e edges after the originating reset/trigger edge.
    function automatic logic [N_CH-1:0] exp_rstb(input int e);
        if (e >= HOLD + 2 * STAGE) return 3'b111;
        if (e >= HOLD + STAGE)     return 3'b011;
        if (e >= HOLD)             return 3'b001;
        return 3'b000;
    endfunction

    task automatic seq_check(input string tag, input logic [1:0] cause_exp);
        for (int e = 1; e <= SEQ_LEN; e++) begin
            tick();
            check($sformatf("%s rstb e%0d", tag, e), bus.RSTb_out, exp_rstb(e));
            check($sformatf("%s ready e%0d", tag, e), bus.ready, (e >= SEQ_LEN));
        end
        check({tag, " cause"}, bus.cause, cause_exp);
    endtask

    task automatic check_trigger(input string tag, input logic [1:0] cause_exp);
        check({tag, " rstb"}, bus.RSTb_out, 3'b000);
        check({tag, " ready"}, bus.ready, 1'b0);
        check({tag, " cause"}, bus.cause, cause_exp);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        bus.swrst_req = 1'b0;
        bus.wdt_en    = 1'b0;
        bus.wdt_kick  = 1'b0;

        // 1: power-on reset and first release sequence
        rst = 1'b1;
        repeat (5) tick();
        check_trigger("por", 2'd0);
        rst = 1'b0;
        seq_check("por", 2'd0);

        // 2: software reset from RUN
        bus.swrst_req = 1'b1;
        tick();
        bus.swrst_req = 1'b0;
        check_trigger("swrst", 2'd1);
        seq_check("swrst", 2'd1);

        // 3: unkicked watchdog fires on the 20th RUN edge
        bus.wdt_en = 1'b1;
        repeat (WDT - 1) tick();
        check("wdt pre rstb", bus.RSTb_out, 3'b111);
        check("wdt pre cause", bus.cause, 2'd1);
        tick();
        check_trigger("wdt", 2'd2);
        bus.wdt_en = 1'b0;
        seq_check("wdt", 2'd2);

        // 4: periodic kicks keep the system running
        begin
            logic dropped = 1'b0;
            bus.wdt_en = 1'b1;
            for (int i = 0; i < 200; i++) begin
                bus.wdt_kick = (i % 10 == 9);
                tick();
                if (bus.RSTb_out != 3'b111) dropped = 1'b1;
            end
            check("kick no drop", dropped, 1'b0);
        end
        check("kick rstb", bus.RSTb_out, 3'b111);
        check("kick cause", bus.cause, 2'd2);

        // 4b: kick landing exactly on the timeout cycle clears the counter
        bus.wdt_kick = 1'b1;
        tick();
        bus.wdt_kick = 1'b0;
        repeat (WDT - 1) tick();
        bus.wdt_kick = 1'b1;
        tick();
        bus.wdt_kick = 1'b0;
        check("edge kick rstb", bus.RSTb_out, 3'b111);
        check("edge kick ready", bus.ready, 1'b1);
        repeat (WDT - 1) tick();
        check("edge kick cleared rstb", bus.RSTb_out, 3'b111);
        tick();
        check_trigger("edge kick later timeout", 2'd2);
        bus.wdt_en = 1'b0;
        seq_check("wdt2", 2'd2);

        // 5: external reset mid-STAGE
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (HOLD + STAGE) tick();
        check("mid stage rstb", bus.RSTb_out, 3'b011);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_trigger("mid stage rst", 2'd0);
        seq_check("mid stage", 2'd0);

        // 6: software reset and watchdog timeout on the same edge
        bus.wdt_en = 1'b1;
        repeat (WDT - 1) tick();
        check("both pre rstb", bus.RSTb_out, 3'b111);
        bus.swrst_req = 1'b1;
        tick();
        bus.swrst_req = 1'b0;
        bus.wdt_en    = 1'b0;
        check_trigger("both", 2'd1);
        seq_check("both", 2'd1);

        // 6b: software reset during HOLD restarts the hold count
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("hold pre cause", bus.cause, 2'd0);
        repeat (5) tick();
        bus.swrst_req = 1'b1;
        tick();
        bus.swrst_req = 1'b0;
        check_trigger("hold swrst", 2'd1);
        seq_check("hold swrst", 2'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
